// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: operand-entry FSM driving add_sub, latching its result; CALC_DEBOUNCE_EN adds enter debounce
module calc_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw,
  input  logic       op_sel,
  input  logic       enter,
  input  logic       clear,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic       s,
  input  logic [3:0] c,
  output logic [3:0] result,
  output logic       result_valid,
  output logic [1:0] state
);
  localparam logic [1:0] GET_A = 2'd0, GET_B = 2'd1, CALC = 2'd2, SHOW = 2'd3;
`ifdef CALC_DEBOUNCE_EN
  localparam int DB = DEBOUNCE_CYCLES;
`else
  localparam int DB = 0;
`endif
  localparam int CW = $clog2(DB + 2);
  logic s1, s2, press;
  logic [CW-1:0] cnt;
  // With DB = 0 the saturating high-run counter degenerates to a plain rising-edge detector
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= enter;
      s2 <= s1;
      cnt <= !s2 ? '0 : cnt == CW'(DB + 1) ? cnt : cnt + 1'b1;
      press <= s2 && cnt == CW'(DB);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      s <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
      state <= GET_A;
    end else if (clear) begin
      a <= '0;
      b <= '0;
      s <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
      state <= GET_A;
    end else begin
      case (state)
        GET_A: if (press) begin
          a <= sw;
          s <= op_sel;
          state <= GET_B;
        end
        GET_B: if (press) begin
          b <= sw;
          state <= CALC;
        end
        CALC: begin
          result <= c;
          result_valid <= 1'b1;
          state <= SHOW;
        end
        default: if (press) begin
          result_valid <= 1'b0;
          a <= sw;
          s <= op_sel;
          state <= GET_B;
        end
      endcase
    end
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl: scoreboard bench with a behavioural add_sub closing the loop
module tb_calc_entry_ctrl;
  localparam logic [1:0] GET_A = 2'd0, GET_B = 2'd1, CALC = 2'd2, SHOW = 2'd3;
`ifdef CALC_DEBOUNCE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, op_sel = 1'b0, enter = 1'b0, clear = 1'b0;
  logic [2:0] sw = '0, a, b;
  logic s, result_valid, rv_q = 1'b0;
  logic [3:0] c, result;
  logic [1:0] state;
  int checks = 0, failures = 0, m_a = 0;
  logic m_s = 1'b0;
  int sbq[$];

  calc_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .op_sel(op_sel), .enter(enter), .clear(clear),
    .a(a), .b(b), .s(s), .c(c), .result(result), .result_valid(result_valid), .state(state)
  );

  assign c = s ? {a[2], a} - {b[2], b} : {a[2], a} + {b[2], b};
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && result_valid && !rv_q) begin
      if (sbq.size() == 0) chk("sb_unexpected", 1, 0);
      else chk("result", int'($signed(result)), sbq.pop_front());
    end
    rv_q = result_valid;
  end

  task automatic do_press(input int v, input logic o, input int hold);
    logic [1:0] st0, nxt;
    @(negedge clk);
    sw = 3'(v);
    op_sel = o;
    enter = 1'b1;
    st0 = state;
    nxt = st0 == GET_B ? CALC : GET_B;
    if (st0 == GET_B) sbq.push_back(m_s ? m_a - v : m_a + v);
    else begin
      m_a = v;
      m_s = o;
    end
    repeat (3 + LAT) @(posedge clk);
    #1 chk("early", int'(state), int'(st0));
    @(posedge clk);
    #1 chk("advance", int'(state), int'(nxt));
    if (nxt == CALC) begin
      chk("b", int'($signed(b)), v);
      chk("rv_in_calc", int'(result_valid), 0);
      @(posedge clk);
      #1 chk("rv_set", int'(result_valid), 1);
      chk("show", int'(state), int'(SHOW));
    end else begin
      chk("a", int'($signed(a)), m_a);
      chk("s", int'(s), int'(m_s));
      chk("rv_low", int'(result_valid), 0);
    end
    repeat (hold) @(posedge clk);
    @(negedge clk) enter = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_a", int'(a), 0);
    chk("rst_b", int'(b), 0);
    chk("rst_s", int'(s), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_rv", int'(result_valid), 0);
    do_press(2, 1'b1, 2);
    @(negedge clk) rst_n = 1'b0;
    #1 chk("midrst_state", int'(state), 0);
    chk("midrst_a", int'(a), 0);
    chk("midrst_s", int'(s), 0);
    @(negedge clk) rst_n = 1'b1;
    do_press(3, 1'b0, 50);
    chk("held_once", int'(state), int'(GET_B));
    do_press(-4, 1'b0, 2);
    chk("add_a", int'($signed(a)), 3);
    chk("add_s", int'(s), 0);
    chk("add_bits", int'(result), 15);
    do_press(3, 1'b1, 2);
    do_press(-4, 1'b1, 2);
    do_press(-4, 1'b1, 2);
    do_press(3, 1'b1, 2);
    do_press(1, 1'b0, 2);
    @(negedge clk) sw = 3'd2;
    enter = 1'b1;
    repeat (3 + LAT) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 chk("clr_state", int'(state), int'(GET_A));
    chk("clr_b", int'(b), 0);
    chk("clr_a", int'(a), 0);
    clear = 1'b0;
    @(negedge clk) enter = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("clr_nocapture", int'(state), int'(GET_A));
`ifdef CALC_DEBOUNCE_EN
    @(negedge clk) enter = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) enter = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("glitch", int'(state), int'(GET_A));
`endif
    do_press(2, 1'b0, 2);
    do_press(1, 1'b0, 2);
    @(negedge clk) clear = 1'b1;
    @(posedge clk);
    #1 chk("clr_show_state", int'(state), int'(GET_A));
    chk("clr_show_result", int'(result), 0);
    chk("clr_show_rv", int'(result_valid), 0);
    clear = 1'b0;
    repeat (3) @(posedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Operand-entry controller sitting directly upstream of `add_sub` in the 3-bit signed calculator. It captures the first operand, the operation and the second operand from switches, one `enter` press at a time. It drives `add_sub`'s `a`, `b` and `s` inputs from registers and latches `add_sub`'s 4-bit signed result `c` for display. Button inputs are synchronised and edge-detected inside the block; debouncing is optional.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: stable-high cycles required on synchronised `enter` before a press is accepted; used only with `CALC_DEBOUNCE_EN`.

Ports:
- `clk`  in  1  single system clock; all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sw`  in  3  signed operand value from switches, two's complement, -4..3.
- `op_sel`  in  1  operation select: 0 = add, 1 = subtract.
- `enter`  in  1  raw asynchronous push button, active-high.
- `clear`  in  1  synchronous abort, active-high, already clean.
- `a`  out  3  registered operand A to `add_sub`.
- `b`  out  3  registered operand B to `add_sub`.
- `s`  out  1  registered operation to `add_sub` (0 add, 1 sub).
- `c`  in  4  signed result from `add_sub`; combinational from `a`, `b`, `s`.
- `result`  out  4  latched signed result.
- `result_valid`  out  1  high while `result` holds a completed calculation.
- `state`  out  2  current FSM state, for LEDs and debug.

## Operation
- Press detection:
  - `enter` passes through a 2-flop synchroniser, then a rising-edge detector.
  - The detector yields a 1-cycle `press` pulse.
  - Holding `enter` high yields exactly one `press`.
- FSM states and encodings:
  - GET_A = 2'd0: on `press`, `a <= sw`, `s <= op_sel`, go to GET_B.
  - GET_B = 2'd1: on `press`, `b <= sw`, go to CALC.
  - CALC = 2'd2: unconditional, exactly one cycle. At its end, `result <= c`, `result_valid <= 1`, go to SHOW.
  - SHOW = 2'd3: on `press`, `result_valid <= 0`, `a <= sw`, `s <= op_sel`, go to GET_B. The press acts as the next A entry.
- `press` arriving in CALC is discarded; it is not queued.
- `clear`:
  - From any state, next edge: state = GET_A; `a`, `b`, `s`, `result`, `result_valid` = 0.
  - `clear` has priority over a simultaneous `press`.
- Width and arithmetic rules:
  - Operands are full 3-bit signed, -4..3.
  - Result range is -8..7 and always fits 4-bit `c`, so no overflow handling exists.
  - `result` is copied verbatim from `c`; the block performs no arithmetic.
- `a`, `b`, `s` change only at the capture edges above, so `c` is stable throughout CALC.

## Timing
- Reset values (asynchronous, while `rst_n` = 0): `a` = 0, `b` = 0, `s` = 0, `result` = 0, `result_valid` = 0, `state` = GET_A; synchroniser and edge flops = 0.
- Reset mid-operation discards all captured operands. No partial result survives.
- Press latency: `enter` first sampled high at edge N → `press` high during cycle after edge N+2 → capture and state change at edge N+3.
- Result latency: capture of `b` at edge M → CALC during cycle M..M+1 → `result` and `result_valid` update at edge M+1.
- `result_valid` deasserts on the same edge that captures a new `a` from SHOW, or on `clear`.
- Back-to-back presses must be separated by at least one cycle with synchronised `enter` low.

## Configuration
- `CALC_DEBOUNCE_EN` defined:
  - A counter requires synchronised `enter` to be high for `DEBOUNCE_CYCLES` consecutive cycles before `press` fires; any low sample resets the counter.
  - Release is not debounced: a single low sample re-arms the detector.
  - Press latency becomes N+3+`DEBOUNCE_CYCLES`.
- `CALC_DEBOUNCE_EN` undefined: no counter; latency N+3 as above; `DEBOUNCE_CYCLES` ignored.

## Test plan
- Reset: hold `rst_n` = 0 mid-GET_B, release → `state` = 0, `a` = `b` = `result` = 0, `result_valid` = 0.
- Add: `sw` = 3, `op_sel` = 0, press; then `sw` = -4, press → `a` = 3, `b` = -4, `s` = 0. With a behavioural `add_sub`: `result` = -1 (4'b1111), `result_valid` = 1 exactly one cycle after the `b` capture edge.
- Subtract extremes: `a` = 3, `b` = -4, `op_sel` = 1 → `result` = 7. Then from SHOW: `a` = -4, `b` = 3, `op_sel` = 1 → `result` = -7, with `result_valid` low between the two results.
- Held button: `enter` high for 50 cycles in GET_A → exactly one state advance, to GET_B.
- `clear` coincident with `press` in GET_B → `state` = GET_A, `b` unchanged at 0, no capture.
- With `CALC_DEBOUNCE_EN`, `DEBOUNCE_CYCLES` = 4:
  - 3-cycle `enter` glitch → no `press`.
  - 4-cycle-stable `enter` → state advances at edge N+7.
